// File: rtl/output_argmax.sv
// Classifier back end: captures the tile's class scores on a done pulse, scans them one per
// cycle for the signed maximum and offers the winning index/value over valid/ready.
module output_argmax #(
  parameter int unsigned OUTPUT_SZ = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W    = $clog2(OUTPUT_SZ)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_done,
  input  logic [OUTPUT_SZ-1:0][DATA_W-1:0]   i_result,
  input  logic                               i_out_ready,
  output logic                               o_out_valid,
  output logic [IDX_W-1:0]                   o_digit,
  output logic [DATA_W-1:0]                  o_max_val,
  output logic                               o_busy,
  output logic                               o_overrun,
  output logic [CNT_W-1:0]                   o_img_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SZ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_e;

  state_e                           r_state, w_state_next;
  logic [OUTPUT_SZ-1:0][DATA_W-1:0] r_res;
  logic [DATA_W-1:0]                r_best_val;
  logic [IDX_W-1:0]                 r_best_idx;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_overrun;
  logic [CNT_W-1:0]                 r_img_count;

  logic              w_accept;
  logic              w_handshake;
  logic [DATA_W-1:0] w_cur;
  logic              w_better;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_done) begin
          w_accept     = 1'b1;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx == LAST_IDX) w_state_next = S_OUT;
      end
      S_OUT: begin
        if (i_out_ready) begin
          w_handshake  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Strict signed compare keeps the earliest index on ties.
  assign w_cur    = r_res[r_idx];
  assign w_better = $signed(w_cur) > $signed(r_best_val);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_idx       <= '0;
      r_overrun   <= 1'b0;
      r_img_count <= '0;
    end else begin
      if (i_done && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (w_handshake) r_img_count <= r_img_count + CNT_W'(1);
      if (w_accept) begin
        r_res      <= i_result;
        r_best_val <= i_result[0];
        r_best_idx <= '0;
        r_idx      <= IDX_W'(1);
      end else if (r_state == S_SCAN) begin
        if (w_better) begin
          r_best_val <= w_cur;
          r_best_idx <= r_idx;
        end
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign o_out_valid = (r_state == S_OUT);
  assign o_busy      = (r_state != S_IDLE);
  assign o_digit     = r_best_idx;
  assign o_max_val   = r_best_val;
  assign o_overrun   = r_overrun;
  assign o_img_count = r_img_count;

endmodule

// File: tb/tb_output_argmax.sv
// Bench for output_argmax: directed vector table, hand-written overrun/reset sequences and
// random images checked against a two-pass argmax reference.
module tb_output_argmax;

  localparam int N  = 10;
  localparam int DW = 32;
  localparam int CW = 4;  // small counter so the wrap is reached quickly

  typedef logic [N-1:0][DW-1:0] scores_t;

  typedef struct {
    scores_t     res;
    int unsigned hold;
    int          exp_digit;
    logic [31:0] exp_max;
    string       name;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          done;
  scores_t       result;
  logic          out_ready;
  logic          out_valid;
  logic [3:0]    digit;
  logic [DW-1:0] max_val;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] img_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  output_argmax #(.OUTPUT_SZ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_done      (done),
    .i_result    (result),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_digit     (digit),
    .o_max_val   (max_val),
    .o_busy      (busy),
    .o_overrun   (overrun),
    .o_img_count (img_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic scores_t rand_scores(input bit narrow);
    scores_t r;
    for (int k = 0; k < N; k++) r[k] = narrow ? ($urandom_range(0, 7) - 32'd4) : $urandom;
    return r;
  endfunction

  // Reference: find the maximum value first, then the first index holding it.
  function automatic void ref_argmax(input scores_t r, output int d, output logic [31:0] m);
    int best;
    best = $signed(r[0]);
    for (int k = 1; k < N; k++) if ($signed(r[k]) > best) best = $signed(r[k]);
    d = -1;
    for (int k = N - 1; k >= 0; k--) if ($signed(r[k]) == best) d = k;
    m = best;
  endfunction

  // Launch one image, scramble the tile bus during the scan, hold off ready, then accept.
  task automatic run_image(input scores_t res, input int unsigned hold, input int exp_d,
                           input logic [31:0] exp_m, input string tag);
    int e;
    @(negedge clk);
    result = res; done = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    done = 1'b0; result = rand_scores(1'b0);
    e = 0;
    while (!out_valid && e < 40) begin
      @(negedge clk);
      result = rand_scores(1'b0);
      e++;
    end
    // e counts edges after the one that sampled done; valid shows in the 10th cycle
    chk({tag, " latency"}, 64'(e), 64'(N - 1));
    chk({tag, " digit"}, 64'(digit), 64'(exp_d));
    chk({tag, " max_val"}, 64'(max_val), 64'(exp_m));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    for (int h = 0; h < int'(hold); h++) begin
      @(negedge clk);
      result = rand_scores(1'b0);
      chk({tag, " held"}, {31'd0, out_valid, busy, digit, max_val[27:0]},
          {31'd0, 1'b1, 1'b1, 4'(exp_d), exp_m[27:0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " img_count"}, 64'(img_count), 64'(exp_count));
  endtask

  initial begin
    vec_t    tbl[6];
    scores_t s;
    int      rd;
    logic [31:0] rm;

    for (int i = 0; i < 6; i++) begin
      tbl[i].res = '0; tbl[i].hold = 0;
    end
    tbl[0].res[7] = 32'h0001_0000;
    tbl[0].exp_digit = 7; tbl[0].exp_max = 32'h0001_0000; tbl[0].name = "basic";
    tbl[1].res[3] = 32'h7FFF_FFFF; tbl[1].res[8] = 32'h7FFF_FFFF;
    tbl[1].exp_digit = 3; tbl[1].exp_max = 32'h7FFF_FFFF; tbl[1].name = "tie";
    for (int k = 0; k < N; k++) tbl[2].res[k] = 32'h8000_0000;
    tbl[2].res[9] = 32'hFFFF_FFFF;
    tbl[2].exp_digit = 9; tbl[2].exp_max = 32'hFFFF_FFFF; tbl[2].name = "signed";
    tbl[3].res[2] = 32'd5; tbl[3].hold = 5;
    tbl[3].exp_digit = 2; tbl[3].exp_max = 32'd5; tbl[3].name = "backpressure";
    for (int k = 0; k < N; k++) tbl[4].res[k] = 32'h1234_5678;
    tbl[4].exp_digit = 0; tbl[4].exp_max = 32'h1234_5678; tbl[4].name = "all_equal";
    for (int k = 0; k < N; k++) tbl[5].res[k] = 32'hFFFF_FFFA;
    tbl[5].res[0] = 32'hFFFF_FFFB;
    tbl[5].exp_digit = 0; tbl[5].exp_max = 32'hFFFF_FFFB; tbl[5].name = "max_at_0";

    rst = 1'b1; done = 1'b0; out_ready = 1'b0; result = '0;
    #12;
    chk("reset outputs", {out_valid, busy, overrun, digit, img_count, max_val},
        {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_image(tbl[i].res, tbl[i].hold, tbl[i].exp_digit, tbl[i].exp_max,
                               tbl[i].name);

    // Enough random images to wrap the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      s = rand_scores(i[0]);
      ref_argmax(s, rd, rm);
      run_image(s, $urandom_range(0, 3), rd, rm, $sformatf("rand%0d", i));
    end
    chk("no overrun yet", 64'(overrun), 64'd0);

    // done arriving together with the handshake is dropped, not accepted.
    s = '0; s[6] = 32'd9;
    @(negedge clk);
    result = s; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (N - 1) @(negedge clk);
    chk("hs+done valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; done = 1'b1; result = tbl[0].res;
    @(negedge clk);
    out_ready = 1'b0; done = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk("hs+done overrun", 64'(overrun), 64'd1);
    @(negedge clk);
    chk("hs+done not accepted", 64'(busy), 64'd0);
    chk("hs+done count", 64'(img_count), 64'(exp_count));

    // Clear, then a second done during the scan must not disturb the first image.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    chk("overrun cleared", 64'(overrun), 64'd0);
    s = '0; s[4] = 32'd100;
    @(negedge clk);
    result = s; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    result = '0; result[1] = 32'd200; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("overrun set", 64'(overrun), 64'd1);
    repeat (N - 5) @(negedge clk);
    chk("overrun valid", 64'(out_valid), 64'd1);
    chk("overrun digit", 64'(digit), 64'd4);
    chk("overrun max", 64'(max_val), 64'd100);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = 1;
    chk("overrun sticky", 64'(overrun), 64'd1);
    chk("overrun count", 64'(img_count), 64'(exp_count));

    // Reset four cycles into a scan: everything clears at once.
    s = '0; s[0] = 32'h00AB_CDEF;
    @(negedge clk);
    result = s; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid-scan reset outputs", {out_valid, busy, overrun, digit, img_count, max_val},
        {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    run_image(tbl[0].res, 0, 7, 32'h0001_0000, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
